// File: rtl/nd_2to1_pkg.sv
// Shared defaults and the output-FSM state type for the nd_2to1 merge node.
// Fixed-priority arbitration is selected with the NS_2TO1_FIXED_PRIO_EN macro.
package nd_2to1_pkg;

    localparam int FSZ_DEF     = 4;
    localparam int ASZ_DEF     = 6;
    localparam int DSZ_DEF     = 8;
    localparam int RSZ_DEF     = 4;
    localparam int REQ_CKS_DEF = 2;
    localparam int ACK_CKS_DEF = 2;

    // Debounce counter width; the CKS parameters must fit in it
    localparam int DB_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } snd_state_e;

endpackage

// File: rtl/nd_msg_fifo.sv
// Per-input message FIFO for nd_2to1; pointers carry one extra wrap bit.
module nd_msg_fifo #(
    parameter int FSZ = 4,
    parameter int MW  = 24
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [MW-1:0] msg_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [MW-1:0] head_o
);

    localparam int IW = $clog2(FSZ);

    logic [IW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [MW-1:0] mem_q [FSZ];

    assign wr_d = push_i ? wr_q + 1'b1 : wr_q;
    assign rd_d = pop_i  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[IW-1:0]] <= msg_i;
    end

    assign full_o  = (wr_q[IW-1:0] == rd_q[IW-1:0]) && (wr_q[IW] != rd_q[IW]);
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[IW-1:0]];

endmodule

// File: rtl/nd_2to1.sv
// nd_2to1: merges two 4-phase req/ack message channels onto one output channel.
// Round-robin arbitration by default; NS_2TO1_FIXED_PRIO_EN makes bf0 always win.
module nd_2to1
    import nd_2to1_pkg::*;
#(
    parameter int FSZ         = FSZ_DEF,
    parameter int ASZ         = ASZ_DEF,
    parameter int DSZ         = DSZ_DEF,
    parameter int RSZ         = RSZ_DEF,
    parameter int RCV_REQ_CKS = REQ_CKS_DEF,
    parameter int SND_ACK_CKS = ACK_CKS_DEF
) (
    input  logic           gch_clk_i,
    input  logic           gch_reset_i,
    output logic           gch_ready_o,
    input  logic [ASZ-1:0] rcv0_src_i,
    input  logic [ASZ-1:0] rcv0_dst_i,
    input  logic [DSZ-1:0] rcv0_dat_i,
    input  logic [RSZ-1:0] rcv0_red_i,
    input  logic           rcv0_req_i,
    output logic           rcv0_ack_o,
    input  logic [ASZ-1:0] rcv1_src_i,
    input  logic [ASZ-1:0] rcv1_dst_i,
    input  logic [DSZ-1:0] rcv1_dat_i,
    input  logic [RSZ-1:0] rcv1_red_i,
    input  logic           rcv1_req_i,
    output logic           rcv1_ack_o,
    output logic [ASZ-1:0] snd0_src_o,
    output logic [ASZ-1:0] snd0_dst_o,
    output logic [DSZ-1:0] snd0_dat_o,
    output logic [RSZ-1:0] snd0_red_o,
    output logic           snd0_req_o,
    input  logic           snd0_ack_i
);

    localparam int MW = 2*ASZ + DSZ + RSZ;

    function automatic logic [DB_CW-1:0] db_load(input int idx);
        return (idx == 2) ? DB_CW'(SND_ACK_CKS) : DB_CW'(RCV_REQ_CKS);
    endfunction

    logic [2:0]       raw;
    logic [2:0]       db_q, db_rdy_q;
    logic [DB_CW-1:0] cnt_q [3];
    logic             rg_rdy_q;

    assign raw = {snd0_ack_i, rcv1_req_i, rcv0_req_i};

    // A raw level is accepted only after it differs from the filtered one for CKS+1 clocks
    always_ff @(posedge gch_clk_i or negedge gch_reset_i) begin
        if (!gch_reset_i) begin
            db_q     <= '0;
            db_rdy_q <= '0;
            rg_rdy_q <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= db_load(i);
        end else begin
            db_rdy_q <= '1;
            rg_rdy_q <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == db_q[i]) begin
                    cnt_q[i] <= db_load(i);
                end else if (cnt_q[i] == '0) begin
                    db_q[i]  <= raw[i];
                    cnt_q[i] <= db_load(i);
                end else begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign gch_ready_o = rg_rdy_q & (&db_rdy_q);

    logic [1:0]    rcv_ack_q, rcv_ack_d, push, pop, full, empty;
    logic [MW-1:0] rcv_msg [2];
    logic [MW-1:0] head    [2];

    assign rcv_msg[0] = {rcv0_src_i, rcv0_dst_i, rcv0_dat_i, rcv0_red_i};
    assign rcv_msg[1] = {rcv1_src_i, rcv1_dst_i, rcv1_dat_i, rcv1_red_i};

    // A pop in this clock frees the slot, so a waiting push can land at once
    always_comb begin
        push      = '0;
        rcv_ack_d = rcv_ack_q;
        for (int i = 0; i < 2; i++) begin
            push[i] = rg_rdy_q & db_q[i] & ~rcv_ack_q[i] & (~full[i] | pop[i]);
            if (push[i])      rcv_ack_d[i] = 1'b1;
            else if (!db_q[i]) rcv_ack_d[i] = 1'b0;
        end
    end

    nd_msg_fifo #(.FSZ(FSZ), .MW(MW)) u_bf0 (
        .clk_i(gch_clk_i), .rst_n_i(gch_reset_i), .push_i(push[0]), .pop_i(pop[0]),
        .msg_i(rcv_msg[0]), .full_o(full[0]), .empty_o(empty[0]), .head_o(head[0])
    );

    nd_msg_fifo #(.FSZ(FSZ), .MW(MW)) u_bf1 (
        .clk_i(gch_clk_i), .rst_n_i(gch_reset_i), .push_i(push[1]), .pop_i(pop[1]),
        .msg_i(rcv_msg[1]), .full_o(full[1]), .empty_o(empty[1]), .head_o(head[1])
    );

    snd_state_e    state_q, state_d;
    logic          sel_q, sel_d, snd_req_q, snd_req_d, gnt;
    logic [MW-1:0] snd_msg_q, snd_msg_d;

`ifdef NS_2TO1_FIXED_PRIO_EN
    assign gnt = empty[0];
`else
    logic rr_q, rr_d;
    // rr_q names the FIFO that wins the next contested grant
    assign gnt = (!empty[0] && !empty[1]) ? rr_q : empty[0];
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        snd_req_d = snd_req_q;
        snd_msg_d = snd_msg_q;
        pop       = '0;
`ifndef NS_2TO1_FIXED_PRIO_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rg_rdy_q && !(&empty)) begin
                    sel_d     = gnt;
                    snd_msg_d = head[gnt];
                    snd_req_d = 1'b1;
                    state_d   = ST_REQ;
`ifndef NS_2TO1_FIXED_PRIO_EN
                    if (!empty[0] && !empty[1]) rr_d = ~gnt;
`endif
                end
            end
            ST_REQ: begin
                if (db_q[2]) begin
                    pop       = sel_q ? 2'b10 : 2'b01;
                    snd_req_d = 1'b0;
                    state_d   = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!db_q[2]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gch_clk_i or negedge gch_reset_i) begin
        if (!gch_reset_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            snd_req_q <= 1'b0;
            snd_msg_q <= '0;
            rcv_ack_q <= '0;
`ifndef NS_2TO1_FIXED_PRIO_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            snd_req_q <= snd_req_d;
            snd_msg_q <= snd_msg_d;
            rcv_ack_q <= rcv_ack_d;
`ifndef NS_2TO1_FIXED_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign rcv0_ack_o = rcv_ack_q[0];
    assign rcv1_ack_o = rcv_ack_q[1];
    assign snd0_req_o = snd_req_q;
    assign {snd0_src_o, snd0_dst_o, snd0_dat_o, snd0_red_o} = snd_msg_q;

endmodule
